// File: rtl/data_memory_pkg.sv
// Shared definitions for the data RAM and its memory-control client:
// access FSM states, RW line encodings and default geometry.
package data_memory_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_WAIT_STATES = 2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ram_array_1rw.sv
// Single-port synchronous word array with write enable and registered read.
// Contents and read register are deliberately left without reset.
module ram_array_1rw
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM behind a wait-state access sequencer with a
// busy/ready handshake and an out-of-range fault flag.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  RW,
    input  logic [31:0]           address_in,
    input  logic [DATA_WIDTH-1:0] RAM_in,
    output logic [DATA_WIDTH-1:0] RAM_out,
    output logic                  busy,
    output logic                  ready,
    output logic                  addr_fault,
    output logic [1:0]            state_o
);

    // Handshake: req is sampled only in IDLE; busy is high from the cycle after
    // accept through DONE, and ready pulses for the single DONE cycle.
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  in_range_q, in_range_d;
    logic                  out_valid_q, out_valid_d;

    logic                  req_in_range;
    logic                  enter_done;
    logic                  arr_we;
    logic                  arr_re;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign req_in_range = (address_in[31:ADDR_WIDTH] == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        in_range_d = in_range_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    rw_d       = RW;
                    addr_d     = address_in[ADDR_WIDTH-1:0];
                    wdata_d    = RAM_in;
                    in_range_d = req_in_range;
                    cnt_d      = CNT_INIT;
                    state_d    = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The *_d request fields equal the live inputs on a zero-wait accept and the
    // latched copy otherwise, so the array read always sees the right address.
    assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    assign arr_re     = enter_done && (rw_d == RW_READ) && in_range_d;
    assign arr_we     = (state_q == ST_DONE) && (rw_q == RW_WRITE) && in_range_q;

    always_comb begin
        out_valid_d = out_valid_q;
        if (enter_done && (rw_d == RW_READ)) begin
            out_valid_d = in_range_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rw_q        <= RW_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            in_range_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            in_range_q  <= in_range_d;
            out_valid_q <= out_valid_d;
        end
    end

    ram_array_1rw #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk_i  (clk),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .addr_i (addr_d),
        .wdata_i(wdata_q),
        .rdata_o(arr_rdata)
    );

    // The array read register has no reset; out_valid_q masks it to zero after
    // reset and after an out-of-range read.
    assign RAM_out    = out_valid_q ? arr_rdata : '0;
    assign busy       = (state_q != ST_IDLE);
    assign ready      = (state_q == ST_DONE);
    assign addr_fault = (state_q == ST_DONE) && !in_range_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance
// driven from a vector table plus hand-written multi-cycle sequences.
module tb_data_memory;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        req2 = 1'b0, rw2 = 1'b1, busy2, rdy2, flt2;
    logic [31:0] addr2 = '0, wd2 = '0, out2;
    logic [1:0]  st2;
    logic        req0 = 1'b0, rw0 = 1'b1, busy0, rdy0, flt0;
    logic [31:0] addr0 = '0, wd0 = '0, out0;
    logic [1:0]  st0;

    data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .req(req2), .RW(rw2), .address_in(addr2),
        .RAM_in(wd2), .RAM_out(out2), .busy(busy2), .ready(rdy2),
        .addr_fault(flt2), .state_o(st2)
    );

    data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .RW(rw0), .address_in(addr0),
        .RAM_in(wd0), .RAM_out(out0), .busy(busy0), .ready(rdy0),
        .addr_fault(flt0), .state_o(st0)
    );

    logic        sel = 1'b0;
    logic        m_ready, m_busy, m_fault;
    logic [31:0] m_out;
    assign m_ready = sel ? rdy0  : rdy2;
    assign m_busy  = sel ? busy0 : busy2;
    assign m_fault = sel ? flt0  : flt2;
    assign m_out   = sel ? out0  : out2;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_rd  = '0;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_f;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rw, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            req0 = r; rw0 = rw; addr0 = a; wd0 = d;
        end else begin
            req2 = r; rw2 = rw; addr2 = a; wd2 = d;
        end
    endtask

    task automatic pop_compare(input string name);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            check({name, "_data"}, 64'(m_out), 64'(e[31:0]));
            check({name, "_fault"}, 64'(m_fault), 64'(e[32]));
        end
    endtask

    // One complete access: accept, wait for ready with a bounded loop, compare.
    task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_f, input string name);
        int n;
        int lat;
        lat = sel ? 1 : 3;
        if (rw) begin
            exp_q.push_back({exp_f, exp_rd});
            last_rd = exp_rd;
        end else begin
            exp_q.push_back({exp_f, last_rd});
        end
        @(negedge clk);
        drive(1'b1, rw, a, d);
        @(posedge clk);
        #1 drive(1'b0, rw, a, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check({name, "_busy"}, 64'(m_busy), 64'(1));
        end while (!m_ready && n < 20);
        check({name, "_latency"}, 64'(n), 64'(lat));
        pop_compare(name);
    endtask

    initial begin
        int rd_cnt;
        logic [31:0] ra, rdat;

        vecs[0]  = '{1'b0, 32'h05,       32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h05,       32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h11,       32'h00000042, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h11,       32'h0,        32'h00000042, 1'b0};
        vecs[4]  = '{1'b0, 32'h12,       32'hCAFEF00D, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 32'h12,       32'h0,        32'hCAFEF00D, 1'b0};
        vecs[6]  = '{1'b0, 32'h00,       32'h11111111, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 32'h100,      32'h12345678, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h100,      32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b1, 32'h00,       32'h0,        32'h11111111, 1'b0};
        vecs[10] = '{1'b0, 32'h07,       32'h0BADC0DE, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b0, 32'h03,       32'h01234567, 32'h0,        1'b0};
        vecs[13] = '{1'b1, 32'h03,       32'h0,        32'h01234567, 1'b0};

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out2",  64'(out2),  64'(0));
        check("rst_busy2", 64'(busy2), 64'(0));
        check("rst_rdy2",  64'(rdy2),  64'(0));
        check("rst_flt2",  64'(flt2),  64'(0));
        check("rst_st2",   64'(st2),   64'(0));
        check("rst_out0",  64'(out0),  64'(0));
        check("rst_busy0", 64'(busy0), 64'(0));
        check("rst_rdy0",  64'(rdy0),  64'(0));
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                   vecs[i].exp_f, $sformatf("vec%0d", i));
        end

        // Request while busy: a write to 0x07 during WAIT must be dropped.
        exp_q.push_back({1'b0, 32'h0BADC0DE});
        last_rd = 32'h0BADC0DE;
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h07, 32'h0);
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 32'h07, 32'h0);
        @(negedge clk);
        check("busyreq_state_wait", 64'(st2), 64'(1));
        drive(1'b1, 1'b0, 32'h07, 32'hFFFFFFFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h07, 32'hFFFFFFFF);
        rd_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_ready) begin
                rd_cnt++;
                pop_compare("busyreq");
            end
            @(negedge clk);
        end
        check("busyreq_ready_count", 64'(rd_cnt), 64'(1));
        access(1'b1, 32'h07, 32'h0, 32'h0BADC0DE, 1'b0, "busyreq_readback");

        // Reset asserted in WAIT of a write aborts it.
        access(1'b1, 32'h03, 32'h0, 32'h01234567, 1'b0, "pre_reset_read");
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h03, 32'hAAAA5555);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 32'h03, 32'hAAAA5555);
        @(negedge clk);
        check("midrst_state_wait", 64'(st2), 64'(1));
        check("midrst_out_before", 64'(out2), 64'(32'h01234567));
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy2), 64'(0));
        check("midrst_ready", 64'(rdy2), 64'(0));
        check("midrst_out", 64'(out2), 64'(0));
        check("midrst_fault", 64'(flt2), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
        access(1'b1, 32'h03, 32'h0, 32'h01234567, 1'b0, "midrst_readback");

        for (int i = 0; i < 6; i++) begin
            ra   = 32'($urandom_range(32'h20, 32'hFF));
            rdat = $urandom;
            access(1'b0, ra, rdat, 32'h0, 1'b0, $sformatf("rnd_wr%0d", i));
            access(1'b1, ra, 32'h0, rdat, 1'b0, $sformatf("rnd_rd%0d", i));
        end

        // Zero wait states with req held high.
        sel = 1'b1;
        last_rd = '0;
        access(1'b0, 32'h00, 32'hA0A00000, 32'h0, 1'b0, "ws0_wr0");
        access(1'b0, 32'h01, 32'hA0A00001, 32'h0, 1'b0, "ws0_wr1");
        access(1'b0, 32'h02, 32'hA0A00002, 32'h0, 1'b0, "ws0_wr2");
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 32'hA0A00000 + 32'(i)});
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h00, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("b2b%0d_ready_hi", i), 64'(rdy0), 64'(1));
            check($sformatf("b2b%0d_busy_hi", i), 64'(busy0), 64'(1));
            pop_compare($sformatf("b2b%0d", i));
            if (i < 2) drive(1'b1, 1'b1, 32'(i + 1), 32'h0);
            else       drive(1'b0, 1'b1, 32'h00, 32'h0);
            @(negedge clk);
            check($sformatf("b2b%0d_ready_lo", i), 64'(rdy0), 64'(0));
            check($sformatf("b2b%0d_busy_lo", i), 64'(busy0), 64'(0));
        end

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data RAM with a wait-state access sequencer. It sits directly downstream of the memory control stage: it consumes the address, write data and RW line that memory control produces, and returns the read word on `RAM_out`. A `busy`/`ready` handshake lets the control path stall LDR/STR/ADR until the access completes.

## Interface

Parameters:
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 8: word-address bits; depth is 2^ADDR_WIDTH (256 words).
- `WAIT_STATES`, 2: extra cycles per access, range 0–15.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: access request strobe, sampled on each edge.
- `RW` in 1: 1 = read, 0 = write; sampled with `req`.
- `address_in` in 32: word address from memory control.
- `RAM_in` in DATA_WIDTH: write data.
- `RAM_out` out DATA_WIDTH: last completed read data.
- `busy` out 1: access in progress.
- `ready` out 1: one-cycle completion pulse.
- `addr_fault` out 1: the completing access was out of range; valid with `ready`.

## Operation

- States: IDLE, WAIT, DONE.
- IDLE:
  - `req`=1 accepts the request and latches `RW`, `address_in` and `RAM_in`.
  - Next state is WAIT, or DONE when WAIT_STATES=0.
  - The wait counter loads WAIT_STATES-1.
- WAIT:
  - The counter decrements each cycle.
  - At 0 the next state is DONE.
- DONE:
  - `ready`=1 for exactly this one cycle.
  - Next state is IDLE.
- `req` is honoured only in IDLE. `req` in WAIT or DONE is ignored, with no queuing.
- Range check: an access is in range when `address_in[31:ADDR_WIDTH]` is all zero.
- Out-of-range access:
  - Write is suppressed and memory is untouched.
  - Read loads `RAM_out` with 0.
  - `addr_fault`=1 during DONE.
- In-range read: the array word at `address_in[ADDR_WIDTH-1:0]` is registered into `RAM_out` on the edge entering DONE.
- In-range write: the array word is updated on the edge leaving DONE. `RAM_out` is unchanged.
- `RAM_out` holds its value in all other cycles, including across writes.
- `busy` = (state != IDLE). It is a combinational decode of the state register.
- Reset behaviour:
  - State goes to IDLE, counter 0, `RAM_out`=0, `ready`=0, `busy`=0, `addr_fault`=0.
  - The array contents are not reset.
- Reset asserted mid-access aborts the access. A write is committed only if the DONE-exit edge occurred before reset.

## Timing

- `req` accepted at edge k: `busy`=1 from cycle k+1 through k+1+WAIT_STATES.
- `ready`=1 in cycle k+1+WAIT_STATES.
- Read data is valid on `RAM_out` in the `ready` cycle and thereafter.
- Write latency: visible to a read accepted at edge k+2+WAIT_STATES or later.
- Minimum access period is WAIT_STATES+2 cycles. The earliest next accept is the edge after DONE.
- `req` held high continuously yields back-to-back accesses, one per WAIT_STATES+2 cycles.
- `req` coincident with reset deassertion: the first edge with `reset`=0 may accept.
- No combinational path from inputs to outputs.

## Structure

- Shared package `data_memory_pkg`:
  - State enum (IDLE, WAIT, DONE).
  - RW encodings `RW_READ`=1 and `RW_WRITE`=0, shared with memory control.
  - Default width constants.
- One sub-module, `ram_array_1rw`:
  - Synchronous single-port array, `DATA_WIDTH` x 2^ADDR_WIDTH.
  - Write-enable and registered read.
  - No reset.
- The FSM, counter, request latches and range check live in `data_memory`.

## Test plan

- **Write/read-back, WAIT_STATES=2:** write 0xDEADBEEF to 0x05, then read 0x05. Each `ready` comes 3 cycles after accept, and `RAM_out`=0xDEADBEEF in the read `ready` cycle.
- **Zero wait states, back-to-back:** with WAIT_STATES=0 and `req` held high, issue reads of 0x00, 0x01, 0x02. `ready` pulses every 2nd cycle, and `busy` toggles 1,0,1,0.
- **Out of range:** write 0x12345678 to 0x100, then read 0x100. `addr_fault`=1 on both `ready` pulses, the read returns 0, and word 0x00 is unchanged.
- **Request while busy:** `req` write to 0x07 asserted in the WAIT cycle is ignored. No extra `ready` occurs, and word 0x07 keeps its prior value.
- **Reset mid-write:** assert `reset` in a WAIT cycle of a write of 0xAAAA5555 to 0x03. Outputs go to 0 immediately, and a later read of 0x03 returns the old value.
- **Read does not disturb RAM_out on write:** after reading 0x11 (value 0x42), a write to 0x12 leaves `RAM_out`=0x42.
